// File: rtl/hbram_burst_resp_if.sv
// Command, write-source, native memory and read-return signals of the HyperRAM burst responder.
// The responder uses the slave view; the command initiator, data source and memory model use the master view.
interface hbram_burst_resp_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ram_en;
  logic [31:0]           ram_addr;
  logic                  ram_rdwr;
  logic                  ram_idle;
  logic                  cmd_err;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_valid;
  logic                  src_ready;
  logic                  mem_cmd_valid;
  logic                  mem_cmd_ready;
  logic                  mem_cmd_we;
  logic [31:0]           mem_cmd_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport slave (
    input  ram_en, ram_addr, ram_rdwr,
    output ram_idle, cmd_err,
    input  src_data, src_valid,
    output src_ready,
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
    input  mem_cmd_ready, mem_rdata, mem_rvalid,
    output rd_data, rd_valid
  );

  modport master (
    output ram_en, ram_addr, ram_rdwr,
    input  ram_idle, cmd_err,
    output src_data, src_valid,
    input  src_ready,
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
    output mem_cmd_ready, mem_rdata, mem_rvalid,
    input  rd_data, rd_valid
  );
endinterface

// File: rtl/hbram_burst_resp.sv
// Accepts one burst command and replays it as BURST_LEN single-beat native memory transfers,
// one outstanding at a time; ram_idle is low from acceptance until the burst has drained.
module hbram_burst_resp #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hbc_cal_pass,
  hbram_burst_resp_if.slave  bus
);

  localparam logic [2:0] INIT     = 3'd0;
  localparam logic [2:0] IDLE     = 3'd1;
  localparam logic [2:0] WR_FETCH = 3'd2;
  localparam logic [2:0] WR_CMD   = 3'd3;
  localparam logic [2:0] RD_CMD   = 3'd4;
  localparam logic [2:0] RD_WAIT  = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic [30:0]          BEAT_BYTES = 31'(DATA_WIDTH / 8);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT  = CNT_WIDTH'(BURST_LEN);

  logic [2:0]            state_reg;
  logic [CNT_WIDTH-1:0]  beat_cnt_reg;
  logic [30:0]           base_reg;

  logic                  ram_idle_reg;
  logic                  cmd_err_reg;
  logic                  src_ready_reg;
  logic                  mem_cmd_valid_reg;
  logic                  mem_cmd_we_reg;
  logic [31:0]           mem_cmd_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg;

  logic [CNT_WIDTH-1:0]  beat_cnt_inc;
  logic [31:0]           addr_cur;
  logic [31:0]           addr_inc;
  logic                  cmd_accept;

  // Beat addresses wrap inside 31 bits; bit 31 is the invalid marker and never leaves the block.
  always_comb begin
    beat_cnt_inc = beat_cnt_reg + CNT_WIDTH'(1);
    addr_cur     = {1'b0, base_reg + 31'(beat_cnt_reg) * BEAT_BYTES};
    addr_inc     = {1'b0, base_reg + 31'(beat_cnt_inc) * BEAT_BYTES};
    cmd_accept   = bus.ram_en && !bus.ram_addr[31] && (state_reg == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= INIT;
      beat_cnt_reg      <= '0;
      base_reg          <= '0;
      ram_idle_reg      <= 1'b0;
      cmd_err_reg       <= 1'b0;
      src_ready_reg     <= 1'b0;
      mem_cmd_valid_reg <= 1'b0;
      mem_cmd_we_reg    <= 1'b0;
      mem_cmd_addr_reg  <= '0;
      mem_wdata_reg     <= '0;
      rd_data_reg       <= '0;
      rd_valid_reg      <= 1'b0;
    end else begin
      // Any strobe that is not an accepted command is reported and dropped, never queued.
      cmd_err_reg  <= bus.ram_en && !cmd_accept;
      rd_valid_reg <= 1'b0;

      case (state_reg)
        INIT: begin
          ram_idle_reg <= 1'b0;
          if (hbc_cal_pass) begin
            state_reg    <= IDLE;
            ram_idle_reg <= 1'b1;
          end
        end

        IDLE: begin
          if (cmd_accept) begin
            base_reg     <= bus.ram_addr[30:0];
            beat_cnt_reg <= '0;
            ram_idle_reg <= 1'b0;
            if (bus.ram_rdwr) begin
              state_reg         <= RD_CMD;
              mem_cmd_valid_reg <= 1'b1;
              mem_cmd_we_reg    <= 1'b0;
              mem_cmd_addr_reg  <= {1'b0, bus.ram_addr[30:0]};
            end else begin
              state_reg     <= WR_FETCH;
              src_ready_reg <= 1'b1;
            end
          end
        end

        WR_FETCH: begin
          if (bus.src_valid && src_ready_reg) begin
            src_ready_reg     <= 1'b0;
            mem_wdata_reg     <= bus.src_data;
            mem_cmd_valid_reg <= 1'b1;
            mem_cmd_we_reg    <= 1'b1;
            mem_cmd_addr_reg  <= addr_cur;
            state_reg         <= WR_CMD;
          end
        end

        WR_CMD: begin
          if (mem_cmd_valid_reg && bus.mem_cmd_ready) begin
            mem_cmd_valid_reg <= 1'b0;
            beat_cnt_reg      <= beat_cnt_inc;
            if (beat_cnt_inc == LAST_BEAT) begin
              state_reg <= DONE;
            end else begin
              state_reg     <= WR_FETCH;
              src_ready_reg <= 1'b1;
            end
          end
        end

        RD_CMD: begin
          if (mem_cmd_valid_reg && bus.mem_cmd_ready) begin
            mem_cmd_valid_reg <= 1'b0;
            state_reg         <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (bus.mem_rvalid) begin
            rd_data_reg  <= bus.mem_rdata;
            rd_valid_reg <= 1'b1;
            beat_cnt_reg <= beat_cnt_inc;
            if (beat_cnt_inc == LAST_BEAT) begin
              state_reg <= DONE;
            end else begin
              state_reg         <= RD_CMD;
              mem_cmd_valid_reg <= 1'b1;
              mem_cmd_we_reg    <= 1'b0;
              mem_cmd_addr_reg  <= addr_inc;
            end
          end
        end

        DONE: begin
          state_reg    <= IDLE;
          ram_idle_reg <= 1'b1;
        end

        default: begin
          state_reg    <= INIT;
          ram_idle_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_idle      = ram_idle_reg;
  assign bus.cmd_err       = cmd_err_reg;
  assign bus.src_ready     = src_ready_reg;
  assign bus.mem_cmd_valid = mem_cmd_valid_reg;
  assign bus.mem_cmd_we    = mem_cmd_we_reg;
  assign bus.mem_cmd_addr  = mem_cmd_addr_reg;
  assign bus.mem_wdata     = mem_wdata_reg;
  assign bus.rd_data       = rd_data_reg;
  assign bus.rd_valid      = rd_valid_reg;

endmodule

// File: tb/tb_hbram_burst_resp.sv
// Bench for hbram_burst_resp: table of burst commands plus random bursts against a queue-based
// model of beat addresses, write-data order and read returns, with hand sequences for init and reset.
module tb_hbram_burst_resp;

  localparam int DW    = 32;
  localparam int BL    = 16;
  localparam int BYTES = DW / 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic hbc_cal_pass = 1'b0;

  always #5 clock = ~clock;

  hbram_burst_resp_if #(.DATA_WIDTH(DW)) bus ();

  hbram_burst_resp #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .CNT_WIDTH (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .hbc_cal_pass(hbc_cal_pass),
    .bus         (bus)
  );

  typedef struct {
    bit          rdwr;
    logic [31:0] addr;
    int          rdy_dly;
    int          rv_dly;
    int          src_pct;
    bit          inject;
    int          exp_beats;
    int          exp_err;
  } vec_t;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // model / scoreboard state
  bit              cur_rdwr = 1'b0;
  logic [31:0]     cur_addr = '0;
  int              rdy_dly = 0;
  int              rv_dly = 1;
  int              src_pct = 100;
  logic [DW-1:0]   exp_wr[$];
  logic [DW-1:0]   exp_rd[$];
  int beat_idx = 0, rd_cnt = 0, err_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  int cyc = 0, rise_cyc = 0, last_done_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] base, input int beat);
    logic [63:0] sum;
    sum = {33'd0, base[30:0]} + 64'(beat) * 64'(BYTES);
    return {1'b0, sum[30:0]};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ram_idle"}, bus.ram_idle, 0);
    check({tag, "_cmd_err"}, bus.cmd_err, 0);
    check({tag, "_src_ready"}, bus.src_ready, 0);
    check({tag, "_mem_cmd_valid"}, bus.mem_cmd_valid, 0);
    check({tag, "_mem_cmd_we"}, bus.mem_cmd_we, 0);
    check({tag, "_mem_cmd_addr"}, bus.mem_cmd_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_rd_data"}, bus.rd_data, 0);
    check({tag, "_rd_valid"}, bus.rd_valid, 0);
  endtask

  task automatic clear_model();
    exp_wr.delete();
    exp_rd.delete();
    beat_idx = 0; rd_cnt = 0; err_cnt = 0; rise_cnt = 0; fall_cnt = 0;
  endtask

  // memory responder: ready after rdy_dly cycles of valid, read data rv_dly cycles after accept
  initial begin : responder
    bit hs_rd;
    bit rst_s;
    int wait_cnt;
    int rv_cnt;
    wait_cnt = 0; rv_cnt = 0;
    bus.mem_cmd_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(negedge clock);
      rst_s = reset;
      hs_rd = bus.mem_cmd_valid && bus.mem_cmd_ready && !bus.mem_cmd_we && !reset;
      @(posedge clock); #1;
      bus.mem_rvalid = 1'b0;
      if (rst_s) begin
        bus.mem_cmd_ready = 1'b0;
        wait_cnt = 0;
        rv_cnt = 0;
      end else begin
        if (hs_rd) rv_cnt = rv_dly;
        if (rv_cnt > 0) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
            exp_rd.push_back(bus.mem_rdata);
          end
        end else if ((!cur_rdwr || bus.mem_cmd_valid) && $urandom_range(5) == 0) begin
          // stray return while no read is waiting; must be ignored
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = $urandom;
        end
        if (rdy_dly == 0) begin
          bus.mem_cmd_ready = 1'b1;
        end else if (bus.mem_cmd_valid) begin
          if (wait_cnt >= rdy_dly) bus.mem_cmd_ready = 1'b1;
          else begin
            bus.mem_cmd_ready = 1'b0;
            wait_cnt++;
          end
        end else begin
          bus.mem_cmd_ready = 1'b0;
          wait_cnt = 0;
        end
      end
    end
  end

  // write-data source: holds each word until it is taken, records taken words in order
  initial begin : source
    bit taken;
    taken = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    forever begin
      @(negedge clock);
      taken = bus.src_valid && bus.src_ready && !reset;
      if (taken) exp_wr.push_back(bus.src_data);
      @(posedge clock); #1;
      if (taken || !bus.src_valid) begin
        bus.src_valid = ($urandom_range(99) < src_pct);
        bus.src_data  = $urandom;
      end
    end
  end

  // monitor: beat addresses/data, stability while waiting, read returns, err pulses, idle edges
  initial begin : monitor
    bit              prev_pend;
    bit              prev_idle;
    logic [31:0]     p_addr;
    bit              p_we;
    logic [DW-1:0]   p_wd;
    logic [DW-1:0]   e;
    prev_pend = 1'b0;
    prev_idle = 1'b0;
    p_addr = '0; p_we = 1'b0; p_wd = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        prev_pend = 1'b0;
        prev_idle = bus.ram_idle;
      end else begin
        if (prev_pend) begin
          check("hold_valid", bus.mem_cmd_valid, 1);
          check("hold_addr", bus.mem_cmd_addr, p_addr);
          check("hold_we", bus.mem_cmd_we, p_we);
          if (p_we) check("hold_wdata", bus.mem_wdata, p_wd);
        end
        if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
          check("beat_we", bus.mem_cmd_we, !cur_rdwr);
          check("beat_addr", bus.mem_cmd_addr, model_addr(cur_addr, beat_idx));
          if (bus.mem_cmd_we) begin
            check("wr_src_avail", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
              e = exp_wr.pop_front();
              check("wr_data", bus.mem_wdata, e);
            end
          end
          beat_idx++;
          if (!cur_rdwr && beat_idx == BL) last_done_cyc = cyc;
        end
        prev_pend = bus.mem_cmd_valid && !bus.mem_cmd_ready;
        p_addr = bus.mem_cmd_addr;
        p_we   = bus.mem_cmd_we;
        p_wd   = bus.mem_wdata;
        if (bus.rd_valid) begin
          check("rd_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            check("rd_data", bus.rd_data, e);
          end
          rd_cnt++;
          if (rd_cnt == BL) last_done_cyc = cyc - 1;
        end
        if (bus.cmd_err) err_cnt++;
        if (bus.ram_idle && !prev_idle) begin
          rise_cnt++;
          rise_cyc = cyc;
        end
        if (!bus.ram_idle && prev_idle) fall_cnt++;
        prev_idle = bus.ram_idle;
      end
    end
  end

  task automatic run_burst(input vec_t v);
    bit injected;
    injected = 1'b0;
    @(posedge clock); #1;
    clear_model();
    cur_rdwr = v.rdwr;
    cur_addr = v.addr;
    rdy_dly  = v.rdy_dly;
    rv_dly   = v.rv_dly;
    src_pct  = v.src_pct;
    bus.ram_en   = 1'b1;
    bus.ram_addr = v.addr;
    bus.ram_rdwr = v.rdwr;
    @(posedge clock); #1;
    bus.ram_en   = 1'b0;
    bus.ram_addr = $urandom;
    bus.ram_rdwr = 1'($urandom);
    @(negedge clock);
    if (v.exp_beats > 0) begin
      check("idle_drop_1cyc", bus.ram_idle, 0);
      check("first_rd_valid_1cyc", bus.mem_cmd_valid, v.rdwr);
      check("first_src_ready_1cyc", bus.src_ready, !v.rdwr);
      for (int i = 0; i < 4000 && rise_cnt == 0; i++) begin
        @(posedge clock); #1;
        bus.ram_en = 1'b0;
        if (v.inject && !injected && beat_idx >= 3 && beat_idx <= 14) begin
          bus.ram_en   = 1'b1;
          bus.ram_addr = $urandom;
          bus.ram_rdwr = 1'($urandom);
          injected = 1'b1;
        end
      end
      bus.ram_en = 1'b0;
      check("burst_finished", rise_cnt > 0, 1);
      repeat (4) @(negedge clock);
      check("beat_count", beat_idx, v.exp_beats);
      check("rd_valid_count", rd_cnt, v.rdwr ? BL : 0);
      check("idle_rise_count", rise_cnt, 1);
      check("idle_fall_count", fall_cnt, 1);
      check("cmd_err_count", err_cnt, v.exp_err);
      check("done_to_idle_2cyc", rise_cyc - last_done_cyc, 2);
    end else begin
      repeat (10) @(negedge clock);
      check("bad_cmd_err_count", err_cnt, v.exp_err);
      check("bad_no_beats", beat_idx, 0);
      check("bad_idle_held", bus.ram_idle, 1);
      check("bad_idle_no_fall", fall_cnt, 0);
      check("bad_no_valid", bus.mem_cmd_valid, 0);
    end
    $display("burst rdwr=%0d addr=0x%08h rdy=%0d rv=%0d beats=%0d rd=%0d err=%0d",
             v.rdwr, v.addr, v.rdy_dly, v.rv_dly, beat_idx, rd_cnt, err_cnt);
  endtask

  vec_t vecs[6];

  initial begin : main
    vec_t v;
    int   rd0, b0;
    vecs[0] = '{1'b0, 32'h0000_0100, 0, 1, 100, 1'b0, BL, 0};
    vecs[1] = '{1'b1, 32'h0000_0200, 3, 2, 100, 1'b0, BL, 0};
    vecs[2] = '{1'b1, 32'h8000_0000, 0, 1, 100, 1'b0, 0, 1};
    vecs[3] = '{1'b0, 32'h7FFF_FFF8, 1, 1, 70, 1'b1, BL, 1};
    vecs[4] = '{1'b1, 32'h7FFF_FFF0, 0, 1, 100, 1'b1, BL, 1};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 2, 1, 100, 1'b0, 0, 1};

    bus.ram_en = 1'b0;
    bus.ram_addr = '0;
    bus.ram_rdwr = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_vals("rst");

    // calibration gate: commands rejected in INIT, idle follows cal_pass by one cycle
    @(posedge clock); #1;
    bus.ram_en = 1'b1;
    bus.ram_addr = 32'h0000_0040;
    @(posedge clock); #1;
    bus.ram_en = 1'b0;
    @(negedge clock);
    check("init_cmd_err", bus.cmd_err, 1);
    check("init_idle_low", bus.ram_idle, 0);
    @(negedge clock);
    check("init_cmd_err_1cyc", bus.cmd_err, 0);
    check("init_no_valid", bus.mem_cmd_valid, 0);
    @(posedge clock); #1;
    hbc_cal_pass = 1'b1;
    @(negedge clock);
    check("cal_idle_not_yet", bus.ram_idle, 0);
    @(negedge clock);
    check("cal_idle_up", bus.ram_idle, 1);

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // calibration loss after INIT must not matter
    hbc_cal_pass = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v.rdwr = 1'($urandom);
      v.addr = $urandom;
      if ($urandom_range(3) == 0) v.addr = 32'h7FFF_FF00 | ($urandom & 32'hFF);
      if ($urandom_range(7) != 0) v.addr[31] = 1'b0;
      v.rdy_dly = $urandom_range(3);
      v.rv_dly  = $urandom_range(1, 3);
      v.src_pct = $urandom_range(30, 100);
      v.inject  = 1'($urandom);
      v.exp_beats = v.addr[31] ? 0 : BL;
      v.exp_err   = (v.addr[31] || v.inject) ? 1 : 0;
      run_burst(v);
    end

    // reset in the middle of beat 5 of a read
    hbc_cal_pass = 1'b1;
    @(posedge clock); #1;
    clear_model();
    cur_rdwr = 1'b1;
    cur_addr = 32'h0000_0300;
    rdy_dly = 0;
    rv_dly = 2;
    bus.ram_en = 1'b1;
    bus.ram_addr = 32'h0000_0300;
    bus.ram_rdwr = 1'b1;
    @(posedge clock); #1;
    bus.ram_en = 1'b0;
    for (int i = 0; i < 2000 && rd_cnt < 4; i++) begin
      @(posedge clock); #1;
    end
    check("reset_at_beat5", rd_cnt, 4);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_reset_vals("midrst");
    @(posedge clock); #1;
    reset = 1'b0;
    rd0 = rd_cnt;
    b0 = beat_idx;
    @(negedge clock);
    check("midrst_init_idle_low", bus.ram_idle, 0);
    @(negedge clock);
    check("midrst_idle_up", bus.ram_idle, 1);
    repeat (10) @(negedge clock);
    check("midrst_no_rd_valid", rd_cnt, rd0);
    check("midrst_no_beats", beat_idx, b0);
    check("midrst_no_valid", bus.mem_cmd_valid, 0);
    $display("reset mid-read: rd=%0d beats=%0d", rd_cnt, beat_idx);

    run_burst(vecs[0]);
    run_burst(vecs[1]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
